alu_divider_rv32i: RTL

ALU_DIVIDER_RV32I -- requirements
Module: alu_divider_rv32i

---
 rtl/alu_divider_rv32i_if.sv | 21 ++
 rtl/alu_divider_rv32i.sv | 105 ++++++++++
 2 files changed

// File: rtl/alu_divider_rv32i_if.sv
// Request/response bundle for the RV32 multi-cycle divider.
// The master drives the request; the slave returns busy, done and the result.
interface alu_divider_rv32i_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] out;

    modport master (
        output start, op, in1, in2,
        input  busy, done, out
    );

    modport slave (
        input  start, op, in1, in2,
        output busy, done, out
    );
endinterface

// File: rtl/alu_divider_rv32i.sv
// RV32 DIV/DIVU/REM/REMU restoring divider: one quotient bit per cycle over magnitudes,
// then sign correction and result select. Fixed 34-edge latency from accept to done.
module alu_divider_rv32i (
    input  logic                        clk,
    input  logic                        rst_n,
    alu_divider_rv32i_if.slave          bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e      r_state;
    logic [1:0]  r_op;
    logic        r_sign_q;
    logic        r_sign_r;
    logic [31:0] r_div;
    logic [31:0] r_dq;
    logic [32:0] r_rem;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_out;

    logic        w_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_rem_shift;
    logic [32:0] w_trial;
    logic        w_qbit;

    // DIV (00) and REM (10) are the signed ops; op[1] selects the remainder.
    assign w_signed = ~bus.op[0];
    assign w_a_mag  = (w_signed && bus.in1[31]) ? (~bus.in1 + 32'd1) : bus.in1;
    assign w_b_mag  = (w_signed && bus.in2[31]) ? (~bus.in2 + 32'd1) : bus.in2;

    // Partial remainder shifted left with the next dividend bit; bit 32 of the trial flags negative.
    assign w_rem_shift = {r_rem[31:0], r_dq[31]};
    assign w_trial     = w_rem_shift - {1'b0, r_div};
    assign w_qbit      = ~w_trial[32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_op     <= 2'b00;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_div    <= 32'd0;
            r_dq     <= 32'd0;
            r_rem    <= 33'd0;
            r_cnt    <= 6'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_out    <= 32'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_op     <= bus.op;
                        // A zero divisor yields an all-ones magnitude quotient that must stay unsigned.
                        r_sign_q <= w_signed && (bus.in1[31] ^ bus.in2[31]) && (bus.in2 != 32'd0);
                        r_sign_r <= w_signed && bus.in1[31];
                        r_div    <= w_b_mag;
                        r_dq     <= w_a_mag;
                        r_rem    <= 33'd0;
                        r_cnt    <= 6'd0;
                        r_busy   <= 1'b1;
                        r_state  <= StCalc;
                    end
                end
                StCalc: begin
                    r_rem <= w_qbit ? w_trial : w_rem_shift;
                    r_dq  <= {r_dq[30:0], w_qbit};
                    if (r_cnt == 6'd31) begin
                        r_cnt   <= 6'd0;
                        r_state <= StFix;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                StFix: begin
                    // First FIX cycle negates, second selects and registers the result.
                    if (r_cnt == 6'd0) begin
                        if (r_sign_q) r_dq <= ~r_dq + 32'd1;
                        if (r_sign_r) r_rem <= {1'b0, ~r_rem[31:0] + 32'd1};
                        r_cnt <= 6'd1;
                    end else begin
                        r_out   <= r_op[1] ? r_rem[31:0] : r_dq;
                        r_cnt   <= 6'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.out  = r_out;
endmodule
